// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type and default widths/latency for hazard_ctrl
package hazard_pkg;
  typedef enum logic {RUN, MUL_BUSY} state_t;
  localparam int RW_DEF      = 5;
  localparam int MUL_LAT_DEF = 4;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use comparator; hazard_o when a load in EX writes a register the ID instruction reads (r0 never hazards)
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic          id_uses_rt_i,
  input  logic          ex_mem_read_i,
  input  logic [RW-1:0] ex_rd_i,
  output logic          hazard_o
);
  assign hazard_o = ex_mem_read_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, taken branches and MUL_LAT-cycle multiply freezes.
// Ports: Clk/Rst (sync, active high); ID_Rs/ID_Rt/ID_UsesRt, EX_MemRead/EX_Rd, EX_MulStart, EX_BranchTaken in;
// PC_En/IFID_En/IDEX_En enables, IFID_Rst/IDEX_Rst clears, Busy out; StallCount out when HAZARD_STATS_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RW      = RW_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CW      = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [RW-1:0] ID_Rs,
  input  logic [RW-1:0] ID_Rt,
  input  logic          ID_UsesRt,
  input  logic          EX_MemRead,
  input  logic [RW-1:0] EX_Rd,
  input  logic          EX_MulStart,
  input  logic          EX_BranchTaken,
  output logic          PC_En,
  output logic          IFID_En,
  output logic          IDEX_En,
  output logic          IFID_Rst,
  output logic          IDEX_Rst,
`ifdef HAZARD_STATS_EN
  output logic [CW-1:0] StallCount,
`endif
  output logic          Busy
);
  if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_lat
    $error("hazard_ctrl: MUL_LAT must be 2..15");
  end
  if (CW < 1) begin : g_bad_cw
    $error("hazard_ctrl: CW must be >= 1");
  end
  state_t     state_q;
  logic [3:0] cnt_q;
  logic       hazard, run, br, mul, lu;
  load_use_detect #(.RW(RW)) u_lud (
    .id_rs_i      (ID_Rs),
    .id_rt_i      (ID_Rt),
    .id_uses_rt_i (ID_UsesRt),
    .ex_mem_read_i(EX_MemRead),
    .ex_rd_i      (EX_Rd),
    .hazard_o     (hazard)
  );
  // branch > multiply > load-use, and nothing is honoured outside RUN
  assign run = (state_q == RUN);
  assign br  = run && EX_BranchTaken;
  assign mul = run && !EX_BranchTaken && EX_MulStart;
  assign lu  = run && !EX_BranchTaken && !EX_MulStart && hazard;
  assign PC_En    = !Rst && run && !mul && !lu;
  assign IFID_En  = !Rst && run && !mul && !lu;
  assign IDEX_En  = !Rst && run && !mul;
  assign IFID_Rst = Rst || br;
  assign IDEX_Rst = Rst || br || lu;
  assign Busy     = !Rst && !run;
  // freeze covers the start cycle plus MUL_LAT-1 busy cycles counted down to 1
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (run) begin
      if (mul) begin
        state_q <= MUL_BUSY;
        cnt_q   <= 4'(MUL_LAT - 1);
      end
    end else begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_q <= RUN;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall_d;
  assign stall_d = (!PC_En && StallCount != '1) ? StallCount + CW'(1) : StallCount;
  always_ff @(posedge Clk) begin
    if (Rst) StallCount <= '0;
    else     StallCount <= stall_d;
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (default RW=5, MUL_LAT=4; CW=2 when HAZARD_STATS_EN is defined)
module tb_hazard_ctrl;
  logic       Clk = 0;
  logic       Rst = 1;
  logic [4:0] ID_Rs = 0, ID_Rt = 0, EX_Rd = 0;
  logic       ID_UsesRt = 0, EX_MemRead = 0, EX_MulStart = 0, EX_BranchTaken = 0;
  logic       PC_En, IFID_En, IDEX_En, IFID_Rst, IDEX_Rst, Busy;
  int         errs = 0, checks = 0;
`ifdef HAZARD_STATS_EN
  logic [1:0] StallCount;
`endif
  always #5 Clk = ~Clk;
  hazard_ctrl #(
    .RW(5), .MUL_LAT(4)
`ifdef HAZARD_STATS_EN
    , .CW(2)
`endif
  ) dut (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .EX_MulStart(EX_MulStart),
    .EX_BranchTaken(EX_BranchTaken), .PC_En(PC_En), .IFID_En(IFID_En), .IDEX_En(IDEX_En),
    .IFID_Rst(IFID_Rst), .IDEX_Rst(IDEX_Rst),
`ifdef HAZARD_STATS_EN
    .StallCount(StallCount),
`endif
    .Busy(Busy)
  );
  // expected vector order: {PC_En, IFID_En, IDEX_En, IFID_Rst, IDEX_Rst, Busy}
  localparam logic [5:0] RST  = 6'b000110;
  localparam logic [5:0] IDLE = 6'b111000;
  localparam logic [5:0] LU   = 6'b001010;
  localparam logic [5:0] BR   = 6'b111110;
  localparam logic [5:0] MS   = 6'b000000;
  localparam logic [5:0] BSY  = 6'b000001;
  task automatic cyc(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    @(negedge Clk);
    got = {PC_En, IFID_En, IDEX_En, IFID_Rst, IDEX_Rst, Busy};
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
    @(posedge Clk);
    #1;
  endtask
  task automatic idle_in();
    ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; EX_MemRead = 0; EX_Rd = 0;
    EX_MulStart = 0; EX_BranchTaken = 0;
  endtask
`ifdef HAZARD_STATS_EN
  task automatic chk_cnt(input string tag, input logic [1:0] exp);
    checks++;
    assert (StallCount === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, StallCount, exp);
    end
  endtask
`endif
  initial begin
    cyc("reset", RST);
    cyc("reset_hold", RST);
    Rst = 0;
`ifdef HAZARD_STATS_EN
    #2 chk_cnt("cnt_after_reset", 2'd0);
`endif
    cyc("idle", IDLE);
    EX_MemRead = 1; EX_Rd = 5; ID_Rs = 5;
    cyc("lu_rs", LU);
    idle_in();
    cyc("lu_resume", IDLE);
    EX_MemRead = 1; EX_Rd = 9; ID_Rt = 9; ID_UsesRt = 1; ID_Rs = 2;
    cyc("lu_rt", LU);
    idle_in(); EX_MemRead = 1;
    cyc("lu_r0", IDLE);
    EX_MemRead = 1; EX_Rd = 7; ID_Rt = 7; ID_Rs = 3; ID_UsesRt = 0;
    cyc("lu_no_rt", IDLE);
    EX_MemRead = 0; EX_Rd = 5; ID_Rs = 5;
    cyc("no_load", IDLE);
    idle_in(); EX_BranchTaken = 1; EX_MemRead = 1; EX_Rd = 5; ID_Rs = 5;
    cyc("br_over_lu", BR);
    idle_in();
    cyc("br_after", IDLE);
    EX_MulStart = 1;
    cyc("mul_n", MS);
    idle_in();
    cyc("mul_n1", BSY);
    EX_BranchTaken = 1; EX_MulStart = 1; EX_MemRead = 1; EX_Rd = 5; ID_Rs = 5;
    cyc("mul_n2_ignore", BSY);
    idle_in();
    cyc("mul_n3", BSY);
    cyc("mul_n4_resume", IDLE);
    EX_BranchTaken = 1; EX_MulStart = 1;
    cyc("br_over_mul", BR);
    idle_in();
    cyc("br_over_mul_after", IDLE);
    EX_MulStart = 1; EX_MemRead = 1; EX_Rd = 4; ID_Rs = 4;
    cyc("mul_over_lu", MS);
    idle_in();
    cyc("mul2_n1", BSY);
    cyc("mul2_n2", BSY);
    cyc("mul2_n3", BSY);
    cyc("mul2_resume", IDLE);
    EX_MulStart = 1;
    cyc("mul3_n", MS);
    idle_in();
    cyc("mul3_n1", BSY);
    Rst = 1;
    cyc("rst_in_busy", RST);
    Rst = 0;
    cyc("rst_abort_run", IDLE);
`ifdef HAZARD_STATS_EN
    chk_cnt("cnt_after_abort", 2'd0);
    for (int i = 0; i < 5; i++) begin
      EX_MemRead = 1; EX_Rd = 6; ID_Rs = 6;
      cyc("stat_lu", LU);
      idle_in();
      cyc("stat_gap", IDLE);
    end
    chk_cnt("cnt_saturate", 2'd3);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RW, default 5: register-address width.
REQ-002 SHALL have parameter MUL_LAT, default 4: EX occupancy of a multi-cycle multiply, in cycles, legal range 2..15.
REQ-003 SHALL have parameter CW, default 16: stall-counter width.
REQ-004 SHALL have port Clk  in  1  system clock; one clock, all state on posedge Clk.
REQ-005 SHALL have port Rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports ID_Rs, ID_Rt  in  RW each  source registers of the instruction in ID.
REQ-007 SHALL have port ID_UsesRt  in  1  ID instruction reads Rt.
REQ-008 SHALL have ports EX_MemRead  in  1  and EX_Rd  in  RW  EX instruction is a load and its destination.
REQ-009 SHALL have port EX_MulStart  in  1  multi-cycle multiply entering EX this cycle.
REQ-010 SHALL have port EX_BranchTaken  in  1  taken branch/jump resolved in EX.
REQ-011 SHALL have ports PC_En, IFID_En, IDEX_En  out  1 each  enables for the PC and pipeline registers.
REQ-012 SHALL have ports IFID_Rst, IDEX_Rst  out  1 each  synchronous clears for IF/ID and ID/EX; each is Rst OR'd with the internal flush.
REQ-013 SHALL have port Busy  out  1  multiply freeze in progress.

Function
REQ-014 SHALL implement FSM states RUN and MUL_BUSY, plus a 4-bit down-counter Cnt.
REQ-015 Default in RUN with no event: all enables 1, both clears 0 (Rst low), Busy 0.
REQ-016 Load-use hazard SHALL be EX_MemRead & (EX_Rd != 0) & (EX_Rd == ID_Rs | (ID_UsesRt & EX_Rd == ID_Rt)).
REQ-017 On a load-use hazard in RUN: PC_En=0, IFID_En=0, IDEX_Rst=1 in the same cycle; exactly one bubble; the state does not change.
REQ-018 On EX_BranchTaken in RUN: IFID_Rst=1, IDEX_Rst=1, all enables 1; the state does not change.
REQ-019 On EX_MulStart in RUN (cycle N): PC_En, IFID_En and IDEX_En SHALL be 0 in cycle N; next state MUL_BUSY with Cnt = MUL_LAT-1.
REQ-020 In MUL_BUSY: all enables 0, clears 0, Busy=1, Cnt decrements each cycle; when Cnt==1, next state is RUN.
REQ-021 Total freeze SHALL be exactly MUL_LAT cycles (N .. N+MUL_LAT-1); normal flow resumes at N+MUL_LAT.
REQ-022 Priority in RUN: branch > multiply start > load-use; a lower-priority event coinciding with a higher one is ignored.
REQ-023 In MUL_BUSY, EX_BranchTaken, EX_MulStart and load-use SHALL be ignored.
REQ-024 All outputs are combinational from state and inputs; no input-to-output path through more than the FSM register.

Reset
REQ-025 While Rst=1: state RUN, Cnt=0, all enables 0, IFID_Rst=1, IDEX_Rst=1, Busy=0; StallCount=0 when present.
REQ-026 Rst asserted in MUL_BUSY SHALL abort the freeze; the first cycle after Rst is in RUN.

Configuration
REQ-027 Macro HAZARD_STATS_EN defined: output StallCount (out, CW) counts cycles with PC_En=0 and Rst=0, saturating at all-ones.
REQ-028 Macro HAZARD_STATS_EN undefined: no StallCount port and no counter logic; all other behaviour is identical.

Structure
REQ-029 Package hazard_pkg SHALL hold the FSM state typedef (RUN, MUL_BUSY) and the default RW/MUL_LAT constants.
REQ-030 The load-use comparator (REQ-016) SHALL be sub-module load_use_detect, purely combinational.

Verification
REQ-031 Load R5 in EX (EX_MemRead=1, EX_Rd=5), ID_Rs=5 -> one cycle PC_En=0, IFID_En=0, IDEX_Rst=1; next cycle all enables 1.
REQ-032 EX_Rd=0 with EX_MemRead=1 and ID_Rs=0 -> no stall; ID_UsesRt=0 with EX_Rd==ID_Rt=7 -> no stall.
REQ-033 EX_MulStart pulse at cycle 10, MUL_LAT=4 -> enables 0 in cycles 10-13, Busy 1 in 11-13, enables 1 at 14.
REQ-034 EX_BranchTaken with a coincident load-use -> IFID_Rst=1, IDEX_Rst=1, PC_En=1, no stall.
REQ-035 Rst in the 2nd cycle of MUL_BUSY -> clears asserted; after Rst is released, RUN with enables 1; StallCount=0 with HAZARD_STATS_EN defined.
REQ-036 With HAZARD_STATS_EN defined, CW=2, five load-use bubbles -> StallCount saturates at 3.
